video_timing_gen: RTL and testbench

Raster timing source that sits directly upstream of the cellular-automaton video stage. It generates the blanking bus, the combined data-enable/vsync/hsync bus, pixel coordinates, a start-of-frame pulse and a frame counter. It also supplies a colour-bar test pattern or passes external video through. Default timing is 1920x1080p60 (CEA-861, 148.5 MHz pixel rate), matching the 96x54 grid of 20-pixel cells.

---
 rtl/video_pkg.sv | 34 +++
 rtl/video_axis_ctr.sv | 62 ++++++
 rtl/video_timing_gen.sv | 131 +++++++++++++
 tb/tb_video_timing_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared timing constants, axis phase type, bus bit positions and colour-bar table
// for the raster timing generator.
package video_pkg;

    localparam int TIM_H_ACTIVE = 1920;
    localparam int TIM_H_FP     = 88;
    localparam int TIM_H_SYNC   = 44;
    localparam int TIM_H_BP     = 148;
    localparam int TIM_V_ACTIVE = 1080;
    localparam int TIM_V_FP     = 4;
    localparam int TIM_V_SYNC   = 5;
    localparam int TIM_V_BP     = 36;
    localparam int TIM_CW       = 12;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } axis_phase_e;

    localparam int DE_B     = 2;
    localparam int VS_B     = 1;
    localparam int HS_B     = 0;
    localparam int HBLANK_B = 0;
    localparam int VBLANK_B = 1;

    // Entry 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_COLOUR = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/video_axis_ctr.sv
// One raster axis: position counter with wrap plus an ACTIVE/FP/SYNC/BP phase FSM
// that always agrees with the count.
module video_axis_ctr
    import video_pkg::*;
#(
    parameter int ACTIVE = TIM_H_ACTIVE,
    parameter int FP     = TIM_H_FP,
    parameter int SYNC   = TIM_H_SYNC,
    parameter int BP     = TIM_H_BP,
    parameter int CW     = TIM_CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          step_i,
    output logic [CW-1:0] cnt_o,
    output axis_phase_e   phase_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LAST       = CW'(ACTIVE + FP + SYNC + BP - 1);
    localparam logic [CW-1:0] FP_START   = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] BP_START   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] cnt_q, cnt_d;
    axis_phase_e   phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap_o  = step_i && (cnt_q == LAST);
        if (step_i) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                phase_d = PH_ACTIVE;
            end else begin
                cnt_d = cnt_q + CW'(1);
                // Phase moves on the count it is about to hold.
                case (phase_q)
                    PH_ACTIVE: if (cnt_d == FP_START)   phase_d = PH_FP;
                    PH_FP:     if (cnt_d == SYNC_START) phase_d = PH_SYNC;
                    PH_SYNC:   if (cnt_d == BP_START)   phase_d = PH_BP;
                    default:   phase_d = phase_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: blank/sync/DE buses, coordinates, start-of-frame, frame count
// and colour-bar or pass-through video, all registered one cen-cycle behind the counters.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE = TIM_H_ACTIVE,
    parameter int   H_FP     = TIM_H_FP,
    parameter int   H_SYNC   = TIM_H_SYNC,
    parameter int   H_BP     = TIM_H_BP,
    parameter int   V_ACTIVE = TIM_V_ACTIVE,
    parameter int   V_FP     = TIM_V_FP,
    parameter int   V_SYNC   = TIM_V_SYNC,
    parameter int   V_BP     = TIM_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = TIM_CW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cen_i,
    input  logic          pattern_en_i,
    input  logic [23:0]   vid_rgb_i,
    output logic [1:0]    vh_blank_o,
    output logic [2:0]    dvh_sync_o,
    output logic [23:0]   vid_rgb_o,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          sof_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int            BAR_W      = H_ACTIVE / 8;
    localparam logic [CW-1:0] BAR_WC     = CW'(BAR_W);
    localparam logic [CW-1:0] BAR7_START = CW'(7 * BAR_W);

    logic [CW-1:0] h_cnt, v_cnt;
    axis_phase_e   h_phase, v_phase;
    logic          h_wrap, v_wrap;

    video_axis_ctr #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .step_i (cen_i),
        .cnt_o  (h_cnt),
        .phase_o(h_phase),
        .wrap_o (h_wrap)
    );

    video_axis_ctr #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_ctr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .step_i (h_wrap),
        .cnt_o  (v_cnt),
        .phase_o(v_phase),
        .wrap_o (v_wrap)
    );

    logic [1:0]    vh_blank_q, vh_blank_d;
    logic [2:0]    dvh_sync_q, dvh_sync_d;
    logic [23:0]   vid_rgb_q, vid_rgb_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          sof_q, sof_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          at_origin_q, at_origin_d;
    logic          hblank, vblank, de;
    logic [2:0]    bar_idx;

    always_comb begin
        hblank = (h_phase != PH_ACTIVE);
        vblank = (v_phase != PH_ACTIVE);
        de     = !hblank && !vblank;
        if (h_cnt >= BAR7_START) bar_idx = 3'd7;
        else                     bar_idx = 3'(h_cnt / BAR_WC);

        vh_blank_d  = vh_blank_q;
        dvh_sync_d  = dvh_sync_q;
        vid_rgb_d   = vid_rgb_q;
        x_d         = x_q;
        y_d         = y_q;
        sof_d       = sof_q;
        frame_cnt_d = frame_cnt_q;
        at_origin_d = at_origin_q;
        if (cen_i) begin
            vh_blank_d[HBLANK_B] = hblank;
            vh_blank_d[VBLANK_B] = vblank;
            dvh_sync_d[DE_B]     = de;
            dvh_sync_d[VS_B]     = (v_phase == PH_SYNC) ? VS_POL : ~VS_POL;
            dvh_sync_d[HS_B]     = (h_phase == PH_SYNC) ? HS_POL : ~HS_POL;
            if (!de)               vid_rgb_d = 24'h000000;
            else if (pattern_en_i) vid_rgb_d = BAR_COLOUR[bar_idx];
            else                   vid_rgb_d = vid_rgb_i;
            x_d   = h_cnt;
            y_d   = v_cnt;
            sof_d = at_origin_q;
            if (at_origin_q) frame_cnt_d = frame_cnt_q + 16'd1;
            // The last pixel of the frame wraps both axes back to the origin.
            at_origin_d = v_wrap;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vh_blank_q  <= 2'b11;
            dvh_sync_q  <= {1'b0, ~VS_POL, ~HS_POL};
            vid_rgb_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            sof_q       <= 1'b0;
            frame_cnt_q <= '0;
            at_origin_q <= 1'b1;
        end else begin
            vh_blank_q  <= vh_blank_d;
            dvh_sync_q  <= dvh_sync_d;
            vid_rgb_q   <= vid_rgb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
            at_origin_q <= at_origin_d;
        end
    end

    assign vh_blank_o  = vh_blank_q;
    assign dvh_sync_o  = dvh_sync_q;
    assign vid_rgb_o   = vid_rgb_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign sof_o       = sof_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-timing instance checked against a raster model
// through a scoreboard, plus a default-1080p instance for the colour bars.
module tb_video_timing_gen;

    localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
    localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

    typedef struct packed {
        logic [1:0]  blank;
        logic [2:0]  sync;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        sof;
        logic [15:0] fcnt;
    } out_t;

    typedef struct {
        logic        rst;
        logic        cen;
        logic        pat;
        logic [23:0] rgb;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, cen = 1'b0, pat = 1'b0;
    logic [23:0] rgb_in = '0;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic [23:0] vid_rgb;
    logic [11:0] x_o, y_o;
    logic        sof;
    logic [15:0] fcnt;

    logic        rst_h = 1'b1, cen_h = 1'b0, pat_h = 1'b1;
    logic [23:0] rgb_h = 24'hABCDEF;
    logic [1:0]  vh_blank_h;
    logic [2:0]  dvh_sync_h;
    logic [23:0] vid_rgb_h;
    logic [11:0] x_h, y_h;
    logic        sof_h;
    logic [15:0] fcnt_h;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .pattern_en_i(pat), .vid_rgb_i(rgb_in),
        .vh_blank_o(vh_blank), .dvh_sync_o(dvh_sync), .vid_rgb_o(vid_rgb),
        .x_o(x_o), .y_o(y_o), .sof_o(sof), .frame_cnt_o(fcnt)
    );

    video_timing_gen dut_hd (
        .clk_i(clk), .rst_i(rst_h), .cen_i(cen_h), .pattern_en_i(pat_h), .vid_rgb_i(rgb_h),
        .vh_blank_o(vh_blank_h), .dvh_sync_o(dvh_sync_h), .vid_rgb_o(vid_rgb_h),
        .x_o(x_h), .y_o(y_h), .sof_o(sof_h), .frame_cnt_o(fcnt_h)
    );

    int   n_cmp = 0, n_bad = 0;
    int   m_h = 0, m_v = 0, m_f = 0;
    out_t m_prev = '0;
    out_t exp_q[$];

    function automatic out_t mk(logic [1:0] b, logic [2:0] s, logic [23:0] c,
                                int x, int y, logic so, int f);
        out_t o;
        o.blank = b; o.sync = s; o.rgb = c;
        o.x = 12'(x); o.y = 12'(y); o.sof = so; o.fcnt = 16'(f);
        return o;
    endfunction

    function automatic logic [23:0] bar_of(int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic out_t model_out(int h, int v, logic p, logic [23:0] d, int f);
        logic hb, vb, de, hs, vs;
        logic [23:0] c;
        hb = (h >= S_HA);
        vb = (v >= S_VA);
        de = !hb && !vb;
        hs = (h >= S_HA + S_HF) && (h <= S_HA + S_HF + S_HS - 1);
        vs = (v >= S_VA + S_VF) && (v <= S_VA + S_VF + S_VS - 1);
        c  = !de ? 24'h0 : (p ? bar_of(h / (S_HA / 8)) : d);
        return mk({vb, hb}, {de, vs, hs}, c, h, v, (h == 0 && v == 0), f);
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, expv);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic p, input logic [23:0] d,
                         input out_t e, input string tag);
        out_t act, want;
        @(negedge clk);
        rst = r; cen = c; pat = p; rgb_in = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        act  = {vh_blank, dvh_sync, vid_rgb, x_o, y_o, sof, fcnt};
        want = exp_q.pop_front();
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got blank=%b sync=%b rgb=%h x=%0d y=%0d sof=%b fcnt=%0d, wanted blank=%b sync=%b rgb=%h x=%0d y=%0d sof=%b fcnt=%0d",
                     tag, act.blank, act.sync, act.rgb, act.x, act.y, act.sof, act.fcnt,
                     want.blank, want.sync, want.rgb, want.x, want.y, want.sof, want.fcnt);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic p,
                              input logic [23:0] d, input string tag);
        out_t e;
        if (r) begin
            m_h = 0; m_v = 0; m_f = 0;
            e = mk(2'b11, 3'b000, 24'h0, 0, 0, 1'b0, 0);
        end else if (c) begin
            if (m_h == 0 && m_v == 0) m_f++;
            e = model_out(m_h, m_v, p, d, m_f);
            m_h++;
            if (m_h == S_HT) begin
                m_h = 0;
                m_v++;
                if (m_v == S_VT) m_v = 0;
            end
        end else begin
            e = m_prev;
        end
        m_prev = e;
        drive(r, c, p, d, e, tag);
    endtask

    vec_t vecs[8];

    initial begin
        int last_sof, de_cnt, hb_rise, hb_line, bad_bar0, bad_blank, bad_x, hd_de;
        logic prev_hb;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 24'h0,      mk(2'b11, 3'b000, 24'h000000, 0, 0, 1'b0, 0)};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 24'h0,      mk(2'b00, 3'b100, 24'hFFFFFF, 0, 0, 1'b1, 1)};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 24'h0,      mk(2'b00, 3'b100, 24'hFFFFFF, 0, 0, 1'b1, 1)};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 24'h777777, mk(2'b00, 3'b100, 24'hFFFFFF, 0, 0, 1'b1, 1)};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 24'h0,      mk(2'b00, 3'b100, 24'hFFFF00, 1, 0, 1'b0, 1)};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 24'h123456, mk(2'b00, 3'b100, 24'h123456, 2, 0, 1'b0, 1)};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 24'h123456, mk(2'b00, 3'b100, 24'h00FF00, 3, 0, 1'b0, 1)};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 24'h0,      mk(2'b00, 3'b100, 24'hFF00FF, 4, 0, 1'b0, 1)};

        for (int i = 0; i < 8; i++)
            drive(vecs[i].rst, vecs[i].cen, vecs[i].pat, vecs[i].rgb, vecs[i].exp,
                  $sformatf("vec%0d", i));

        // Two full frames at cen=1 with random pattern/pass-through mixing.
        model_step(1'b1, 1'b1, 1'b0, 24'h0, "frame_rst");
        last_sof = -1; de_cnt = 0; hb_rise = 0; hb_line = 0; prev_hb = 1'b1;
        for (int i = 0; i <= 2 * S_HT * S_VT; i++) begin
            model_step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 24'($urandom), "frame");
            if (sof) begin
                if (last_sof >= 0) check("sof_period", i - last_sof, S_HT * S_VT);
                last_sof = i;
            end
            if (i < 2 * S_HT * S_VT) begin
                if (dvh_sync[2]) de_cnt++;
                if (vh_blank[0] && !prev_hb) hb_rise++;
                if (i < S_HT && vh_blank[0]) hb_line++;
            end
            prev_hb = vh_blank[0];
        end
        check("frame_cnt_after_2", fcnt, 3);
        check("de_cycles_2frames", de_cnt, 2 * S_HA * S_VA);
        check("hblank_rises_2frames", hb_rise, 2 * S_VT);
        check("hblank_cycles_line0", hb_line, S_HT - S_HA);

        // Pass-through with a fixed value, including blanking.
        for (int i = 0; i < S_HT + 2; i++)
            model_step(1'b0, 1'b1, 1'b0, 24'h123456, "passthru");

        // Random cen gaps.
        for (int i = 0; i < 60; i++)
            model_step(1'b0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                       24'($urandom), "cen_rand");

        // Mid-frame reset while cen is low, then restart.
        model_step(1'b1, 1'b1, 1'b1, 24'h0, "mid_rst0");
        for (int i = 0; i < 2 * S_HT + 5; i++)
            model_step(1'b0, 1'b1, 1'b1, 24'h0, "mid_run");
        model_step(1'b1, 1'b0, 1'b1, 24'h0, "mid_rst");
        model_step(1'b0, 1'b0, 1'b1, 24'h0, "mid_hold");
        model_step(1'b0, 1'b1, 1'b1, 24'h0, "mid_first");
        check("mid_first_sof", sof, 1);
        check("mid_first_fcnt", fcnt, 1);
        @(negedge clk);
        cen = 1'b0;

        // Default 1080p instance: first line of colour bars.
        @(negedge clk);
        rst_h = 1'b1; cen_h = 1'b1; pat_h = 1'b1;
        @(posedge clk);
        #1;
        check("hd_reset_blank", vh_blank_h, 2'b11);
        @(negedge clk);
        rst_h = 1'b0;
        bad_bar0 = 0; bad_blank = 0; bad_x = 0; hd_de = 0;
        for (int i = 0; i < 2200; i++) begin
            @(posedge clk);
            #1;
            if (x_h != 12'(i) || y_h != 12'd0) bad_x++;
            if (dvh_sync_h[2]) hd_de++;
            if (i < 240 && vid_rgb_h != 24'hFFFFFF) bad_bar0++;
            if (i == 0) check("hd_sof", sof_h, 1);
            if (i == 240) check("hd_x240", vid_rgb_h, 24'hFFFF00);
            if (i == 1919) check("hd_x1919", vid_rgb_h, 24'h000000);
            if (i == 1920) check("hd_hblank_1920", vh_blank_h, 2'b01);
            if (i == 1919 + 89) check("hd_hsync_start", dvh_sync_h, 3'b001);
            if (i == 1919 + 88) check("hd_hsync_pre", dvh_sync_h, 3'b000);
            if (i >= 1920 && (vid_rgb_h != 24'h0 || dvh_sync_h[2])) bad_blank++;
        end
        check("hd_x_sequence", bad_x, 0);
        check("hd_bar0", bad_bar0, 0);
        check("hd_blank_black", bad_blank, 0);
        check("hd_de_line", hd_de, 1920);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
